// File: rtl/router_in_buffer.sv
// Ring-router input buffer: one packet per virtual channel, accepted on the
// polarity-selected VC and routed (cw / ccw / local PE) on the opposite phase.
module router_in_buffer #(
  parameter int DATA_W  = 64,
  parameter int HOP_LSB = 48,
  parameter int HOP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              in_si,
  output logic              in_ri,
  input  logic [DATA_W-1:0] in_di,
  output logic              req_cw,
  output logic              req_ccw,
  output logic              req_pe,
  input  logic              gnt,
  output logic [DATA_W-1:0] fwd_do,
  output logic              err_vc
);

  logic [DATA_W-1:0] buf_q [2];
  logic [1:0]        full_q;

  logic              fwd_vc;
  logic [DATA_W-1:0] head;
  logic [HOP_W-1:0]  hop;
  logic              dir;
  logic              accept;
  logic              vc_match;

  assign fwd_vc   = ~polarity;
  assign head     = buf_q[fwd_vc];
  assign hop      = head[HOP_LSB +: HOP_W];
  assign dir      = head[DATA_W-2];

  assign in_ri    = ~full_q[polarity];
  assign accept   = in_si & in_ri;
  assign vc_match = (in_di[DATA_W-1] == polarity);

  // Hop is halved on every ring hop; a zero hop means the packet has arrived.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    req_cw  = 1'b0;
    req_ccw = 1'b0;
    req_pe  = 1'b0;
    fwd_do  = '0;
    if (full_q[fwd_vc]) begin
      fwd_do = head;
      if (hop == '0) begin
        req_pe = 1'b1;
      end else begin
        req_cw  = ~dir;
        req_ccw = dir;
        fwd_do[HOP_LSB +: HOP_W] = hop >> 1;
      end
    end
  end

  // Write and forward always target different VCs, so both may fire in one cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all reads see pre-edge values.
    if (reset) begin
      full_q   <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      err_vc   <= 1'b0;
    end else begin
      err_vc <= accept & ~vc_match;
      if (accept && vc_match) begin
        buf_q[polarity]  <= in_di;
        full_q[polarity] <= 1'b1;
      end
      if (gnt && full_q[fwd_vc]) begin
        full_q[fwd_vc] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_in_buffer.sv
// Randomized self-checking bench for router_in_buffer against a per-VC
// packet-slot reference model.
module tb_router_in_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        in_si;
  logic        in_ri;
  logic [63:0] in_di;
  logic        req_cw, req_ccw, req_pe;
  logic        gnt;
  logic [63:0] fwd_do;
  logic        err_vc;

  int checks = 0;
  int errors = 0;

  // Reference model: one packet slot per VC plus the pending error pulse.
  logic [63:0] m_pkt  [2];
  bit          m_held [2];
  bit          m_err;

  router_in_buffer #(.DATA_W(64), .HOP_LSB(48), .HOP_W(8)) dut (
    .clk(clk), .reset(reset), .polarity(polarity), .in_si(in_si), .in_ri(in_ri),
    .in_di(in_di), .req_cw(req_cw), .req_ccw(req_ccw), .req_pe(req_pe),
    .gnt(gnt), .fwd_do(fwd_do), .err_vc(err_vc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-low phase and compare every output with the model.
  task automatic drive(input bit r, input bit p, input bit si, input logic [63:0] di, input bit g);
    int q;
    logic [63:0] pkt;
    logic [2:0] exp_req;
    @(negedge clk);
    reset = r; polarity = p; in_si = si; in_di = di; gnt = g;
    #1;
    q = p ? 0 : 1;
    pkt = 64'h0;
    exp_req = 3'b000; // {cw, ccw, pe}
    if (m_held[q]) begin
      pkt = m_pkt[q];
      if (pkt[55:48] == 8'd0) exp_req = 3'b001;
      else begin
        exp_req = pkt[62] ? 3'b010 : 3'b100;
        pkt[55:48] = pkt[55:48] / 2;
      end
    end
    check("in_ri", in_ri, !m_held[p]);
    check("req", {req_cw, req_ccw, req_pe}, exp_req);
    check("fwd_do", fwd_do, pkt);
    check("err_vc", err_vc, m_err);
  endtask

  // Clock edge: advance the model with the inputs applied by drive().
  task automatic tick();
    int p, q;
    bit took;
    @(posedge clk);
    p = polarity ? 1 : 0;
    q = 1 - p;
    if (reset) begin
      m_held[0] = 0; m_held[1] = 0; m_pkt[0] = '0; m_pkt[1] = '0; m_err = 0;
    end else begin
      took = in_si && !m_held[p];
      m_err = took && (in_di[63] != polarity);
      if (gnt && m_held[q]) m_held[q] = 0;
      if (took && in_di[63] == polarity) begin
        m_pkt[p]  = in_di;
        m_held[p] = 1;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit p, input bit si, input logic [63:0] di, input bit g);
    drive(r, p, si, di, g);
    tick();
  endtask

  initial begin
    logic [63:0] rnd;
    bit pol;
    m_held[0] = 0; m_held[1] = 0; m_pkt[0] = '0; m_pkt[1] = '0; m_err = 0;
    reset = 1; polarity = 0; in_si = 0; in_di = '0; gnt = 0;
    repeat (2) @(posedge clk);

    // Idle after reset.
    for (int i = 0; i < 4; i++) cyc(0, i[0], 0, 64'h0, 0);

    // VC1 cw packet, hop 3 -> 1, granted on first request.
    cyc(0, 1, 1, 64'h8003_0000_0000_00AA, 0);
    drive(0, 0, 0, 64'h0, 1);
    check("tp_cw_req", req_cw, 1'b1);
    check("tp_cw_fwd", fwd_do, 64'h8001_0000_0000_00AA);
    tick();
    cyc(0, 1, 0, 64'h0, 0);
    drive(0, 0, 0, 64'h0, 0);
    check("tp_cw_gone", {req_cw, req_ccw, req_pe}, 3'b000);
    tick();

    // VC0 local-PE packet held through three ungranted phases.
    cyc(0, 1, 0, 64'h0, 0);
    cyc(0, 0, 1, 64'h4000_0000_0000_0055, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 64'h0, 0);
      check("tp_pe_req", req_pe, 1'b1);
      check("tp_pe_fwd", fwd_do, 64'h4000_0000_0000_0055);
      tick();
      drive(0, 0, 1, 64'h0000_0000_0000_0001, 0);
      check("tp_pe_full", in_ri, 1'b0);
      tick();
    end
    cyc(0, 1, 0, 64'h0, 1);

    // VC bit mismatch: dropped, one-cycle error pulse.
    drive(0, 0, 1, 64'h8000_0000_0000_0011, 0);
    check("tp_err_ri", in_ri, 1'b1);
    tick();
    drive(0, 1, 0, 64'h0, 0);
    check("tp_err_pulse", err_vc, 1'b1);
    tick();
    drive(0, 0, 0, 64'h0, 0);
    check("tp_err_once", err_vc, 1'b0);
    check("tp_err_ri2", in_ri, 1'b1);
    tick();

    // VC1 forwarded while VC0 is written in the same cycle.
    cyc(0, 1, 1, 64'h8010_0000_0000_1234, 0);
    drive(0, 0, 1, 64'h0004_0000_0000_5678, 1);
    check("tp_sim_fwd", fwd_do, 64'h8008_0000_0000_1234);
    tick();
    drive(0, 1, 0, 64'h0, 0);
    check("tp_sim_vc0", fwd_do, 64'h0002_0000_0000_5678);
    tick();
    cyc(0, 0, 1, 64'h0, 0);
    cyc(0, 1, 1, 64'hC020_0000_0000_0777, 0);

    // Reset with both VCs full and req_ccw asserted.
    drive(1, 0, 0, 64'h0, 0);
    check("tp_rst_ccw", req_ccw, 1'b1);
    tick();
    drive(0, 1, 0, 64'h0, 0);
    check("tp_rst_out", {in_ri, req_cw, req_ccw, req_pe, err_vc}, 5'b10000);
    check("tp_rst_fwd", fwd_do, 64'h0);
    tick();
    cyc(0, 0, 1, 64'h0002_0000_0000_0099, 0);
    drive(0, 1, 0, 64'h0, 1);
    check("tp_rst_first", fwd_do, 64'h0001_0000_0000_0099);
    tick();

    // Random traffic; polarity occasionally stalls, resets are rare.
    pol = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(9) != 0) pol = ~pol;
      rnd = {$urandom, $urandom};
      if ($urandom_range(4) != 0) rnd[63] = pol;
      if ($urandom_range(3) == 0) rnd[55:48] = 8'h00;
      cyc($urandom_range(49) == 0, pol, $urandom_range(2) != 0, rnd, $urandom_range(1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
